// File: rtl/issue_read_pipe_pkg.sv
// issue_read_pipe_pkg: shared types and constants for the integer issue read pipeline
package issue_read_pipe_pkg;
   localparam int NUMSRCS_INT = 2;
   localparam int BYP_NUM_DEF = 2;
   localparam int LDU_NUM     = 2;
   localparam int IPR_W       = 6;
   localparam int IQ_DEPTH    = 16;
   localparam int IQ_IDX_W    = $clog2(IQ_DEPTH);

   typedef logic [IPR_W-1:0]    iprIdx_t;
   typedef logic [31:0]         word_t;
   typedef logic [IQ_IDX_W-1:0] iqIdx_t;

   typedef struct packed {
      iqIdx_t                        iqIdx;
      iprIdx_t [NUMSRCS_INT-1:0]     iprs;
      iprIdx_t                       iprd;
      logic                          useImm;
      word_t                         imm;
      logic [3:0]                    op;
   } issueState_t;

   typedef struct packed {
      issueState_t               st;
      word_t [NUMSRCS_INT-1:0]   srcData;
   } exeInfo_t;

   // True when any source of the op depends on a load whose result was cancelled.
   function automatic logic ldc_hit(issueState_t st, logic [LDU_NUM-1:0] vld,
                                    iprIdx_t [LDU_NUM-1:0] iprd);
      ldc_hit = 1'b0;
      for (int s = 0; s < NUMSRCS_INT; s++)
         for (int l = 0; l < LDU_NUM; l++)
            ldc_hit = ldc_hit | (vld[l] & (st.iprs[s] == iprd[l]));
   endfunction
endpackage

// File: rtl/issue_read_pipe_operand_bypass_mux.sv
// operand_bypass_mux: one source operand from x0, lowest-index live bypass, or regfile data
module operand_bypass_mux
   import issue_read_pipe_pkg::*;
#(
   parameter int BYP_NUM = BYP_NUM_DEF
) (
   input  iprIdx_t                iprs_i,
   input  word_t                  rf_data_i,
   input  logic [BYP_NUM-1:0]     byp_vld_i,
   input  iprIdx_t [BYP_NUM-1:0]  byp_iprd_i,
   input  word_t [BYP_NUM-1:0]    byp_data_i,
   output word_t                  data_o
);
   // Scan high to low so the lowest-index hit is the last writer.
   always_comb begin
      data_o = rf_data_i;
      for (int b = BYP_NUM - 1; b >= 0; b--)
         data_o = (byp_vld_i[b] && byp_iprd_i[b] == iprs_i) ? byp_data_i[b] : data_o;
      data_o = (iprs_i == '0) ? '0 : data_o;
   end
endmodule

// File: rtl/issue_read_pipe.sv
// issue_read_pipe: i1 regfile read and i2 operand assembly / issue decision, one lane per port
module issue_read_pipe
   import issue_read_pipe_pkg::*;
#(
   parameter int PORTS   = 2,
   parameter int BYP_NUM = BYP_NUM_DEF,
   parameter int CNT_W   = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      i_flush,
   input  logic [PORTS-1:0]                          i_can_issue,
   input  issueState_t [PORTS-1:0]                   i_issueState,
   output logic [PORTS-1:0]                          o_fu_busy,
   output logic [PORTS-1:0][NUMSRCS_INT-1:0]         o_rf_ren,
   output iprIdx_t [PORTS-1:0][NUMSRCS_INT-1:0]      o_rf_ridx,
   input  word_t [PORTS-1:0][NUMSRCS_INT-1:0]        i_rf_rdata,
   input  logic [BYP_NUM-1:0]                        i_byp_vld,
   input  iprIdx_t [BYP_NUM-1:0]                     i_byp_iprd,
   input  word_t [BYP_NUM-1:0]                       i_byp_data,
   input  logic [LDU_NUM-1:0]                        i_ldc_vld,
   input  iprIdx_t [LDU_NUM-1:0]                     i_ldc_iprd,
   output logic [PORTS-1:0]                          o_fu_vld,
   output exeInfo_t [PORTS-1:0]                      o_fu_info,
   input  logic [PORTS-1:0]                          i_fu_rdy,
   output logic [PORTS-1:0]                          o_issueSuccess,
   output logic [PORTS-1:0]                          o_issueReplay,
   output iqIdx_t [PORTS-1:0]                        o_feedbackIdx,
   output logic [CNT_W-1:0]                          o_replay_cnt
);
   logic [PORTS-1:0]                   i2_vld_q, i2_vld_d, c1_q, c1_d, fu_busy_q, live, cancel;
   issueState_t [PORTS-1:0]            st_q;
   word_t [PORTS-1:0][NUMSRCS_INT-1:0] src;
   logic [CNT_W-1:0]                   cnt_q, cnt_d;
   logic [CNT_W:0]                     sum;

   for (genvar p = 0; p < PORTS; p++) begin : g_lane
      for (genvar s = 0; s < NUMSRCS_INT; s++) begin : g_src
         operand_bypass_mux #(.BYP_NUM(BYP_NUM)) u_mux (
            .iprs_i     (st_q[p].iprs[s]),
            .rf_data_i  (i_rf_rdata[p][s]),
            .byp_vld_i  (i_byp_vld),
            .byp_iprd_i (i_byp_iprd),
            .byp_data_i (i_byp_data),
            .data_o     (src[p][s])
         );
      end
   end

   always_comb begin
      for (int p = 0; p < PORTS; p++) begin
         c1_d[p]           = ldc_hit(i_issueState[p], i_ldc_vld, i_ldc_iprd);
         live[p]           = i2_vld_q[p] & ~i_flush;
         cancel[p]         = c1_q[p] | ldc_hit(st_q[p], i_ldc_vld, i_ldc_iprd);
         o_rf_ren[p]       = {NUMSRCS_INT{i_can_issue[p]}};
         o_rf_ridx[p]      = i_issueState[p].iprs;
         o_issueReplay[p]  = live[p] & (cancel[p] | ~i_fu_rdy[p]);
         o_issueSuccess[p] = live[p] & ~cancel[p] & i_fu_rdy[p];
         o_feedbackIdx[p]  = live[p] ? st_q[p].iqIdx : '0;
         o_fu_info[p]      = live[p] ? {st_q[p], src[p]} : '0;
      end
   end

   // Worst-case sum stays below 2^(CNT_W+1), so the carry bit alone flags overflow.
   always_comb begin
      sum = {1'b0, cnt_q};
      for (int p = 0; p < PORTS; p++)
         sum = sum + (CNT_W+1)'(o_issueReplay[p]);
   end

   assign cnt_d        = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   assign i2_vld_d     = i_can_issue & {PORTS{~i_flush}};
   assign o_fu_vld     = o_issueSuccess;
   assign o_fu_busy    = fu_busy_q;
   assign o_replay_cnt = cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i2_vld_q  <= '0;
         c1_q      <= '0;
         st_q      <= '0;
         fu_busy_q <= '0;
         cnt_q     <= '0;
      end else begin
         i2_vld_q  <= i2_vld_d;
         c1_q      <= c1_d;
         st_q      <= i_issueState;
         fu_busy_q <= ~i_fu_rdy;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_issue_read_pipe.sv
// tb_issue_read_pipe: directed scenarios plus random traffic against a lane-level reference model
module tb_issue_read_pipe;
   import issue_read_pipe_pkg::*;
   localparam int P    = 2;
   localparam int NB   = BYP_NUM_DEF;
   localparam int CW   = 5;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_flush;
   logic [P-1:0] i_can_issue, o_fu_busy, o_fu_vld, i_fu_rdy, o_issueSuccess, o_issueReplay;
   issueState_t [P-1:0] i_issueState;
   logic [P-1:0][NUMSRCS_INT-1:0] o_rf_ren;
   iprIdx_t [P-1:0][NUMSRCS_INT-1:0] o_rf_ridx;
   word_t [P-1:0][NUMSRCS_INT-1:0] i_rf_rdata;
   logic [NB-1:0] i_byp_vld;
   iprIdx_t [NB-1:0] i_byp_iprd;
   word_t [NB-1:0] i_byp_data;
   logic [LDU_NUM-1:0] i_ldc_vld;
   iprIdx_t [LDU_NUM-1:0] i_ldc_iprd;
   exeInfo_t [P-1:0] o_fu_info;
   iqIdx_t [P-1:0] o_feedbackIdx;
   logic [CW-1:0] o_replay_cnt;

   issue_read_pipe #(.PORTS(P), .BYP_NUM(NB), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .i_flush(i_flush), .i_can_issue(i_can_issue),
      .i_issueState(i_issueState), .o_fu_busy(o_fu_busy), .o_rf_ren(o_rf_ren),
      .o_rf_ridx(o_rf_ridx), .i_rf_rdata(i_rf_rdata), .i_byp_vld(i_byp_vld),
      .i_byp_iprd(i_byp_iprd), .i_byp_data(i_byp_data), .i_ldc_vld(i_ldc_vld),
      .i_ldc_iprd(i_ldc_iprd), .o_fu_vld(o_fu_vld), .o_fu_info(o_fu_info),
      .i_fu_rdy(i_fu_rdy), .o_issueSuccess(o_issueSuccess), .o_issueReplay(o_issueReplay),
      .o_feedbackIdx(o_feedbackIdx), .o_replay_cnt(o_replay_cnt)
   );

   always #5 clk = ~clk;

   int errs = 0, checks = 0, ecnt = 0;
   logic [P-1:0] pv = '0, pc1 = '0, ebusy = '0, er = '0;
   issueState_t pst [P];

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic hit(issueState_t st);
      for (int s = 0; s < NUMSRCS_INT; s++)
         for (int l = 0; l < LDU_NUM; l++)
            if (i_ldc_vld[l] && st.iprs[s] == i_ldc_iprd[l]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic word_t opnd(iprIdx_t r, word_t rf);
      if (r == 0) return '0;
      for (int b = 0; b < NB; b++)
         if (i_byp_vld[b] && i_byp_iprd[b] == r) return i_byp_data[b];
      return rf;
   endfunction

   task automatic idle();
      i_flush = 1'b0; i_can_issue = '0; i_issueState = '0; i_rf_rdata = '0;
      i_byp_vld = '0; i_byp_iprd = '0; i_byp_data = '0;
      i_ldc_vld = '0; i_ldc_iprd = '0; i_fu_rdy = '1;
   endtask

   task automatic set_op(int p, int iq, int r0, int r1);
      i_issueState[p].iqIdx   = iqIdx_t'(iq);
      i_issueState[p].iprs[0] = iprIdx_t'(r0);
      i_issueState[p].iprs[1] = iprIdx_t'(r1);
      i_issueState[p].iprd    = iprIdx_t'($urandom);
      i_issueState[p].useImm  = 1'($urandom);
      i_issueState[p].imm     = $urandom;
      i_issueState[p].op      = 4'($urandom);
   endtask

   task automatic rand_in();
      i_flush     = ($urandom_range(0, 15) == 0);
      i_can_issue = P'($urandom);
      for (int p = 0; p < P; p++) begin
         set_op(p, $urandom, $urandom_range(0, 7), $urandom_range(0, 7));
         for (int s = 0; s < NUMSRCS_INT; s++) i_rf_rdata[p][s] = $urandom;
      end
      for (int b = 0; b < NB; b++) begin
         i_byp_vld[b]  = 1'($urandom);
         i_byp_iprd[b] = iprIdx_t'($urandom_range(0, 7));
         i_byp_data[b] = $urandom;
      end
      for (int l = 0; l < LDU_NUM; l++) begin
         i_ldc_vld[l]  = ($urandom_range(0, 3) == 0);
         i_ldc_iprd[l] = iprIdx_t'($urandom_range(0, 7));
      end
      i_fu_rdy = P'($urandom);
   endtask

   // Expected i2 results from the op captured last cycle and this cycle's inputs.
   task automatic check_model();
      exeInfo_t ei;
      logic live, canc, ok;
      #3;
      for (int p = 0; p < P; p++) begin
         live  = pv[p] && !i_flush;
         canc  = pc1[p] || hit(pst[p]);
         ok    = live && !canc && i_fu_rdy[p];
         er[p] = live && !ok;
         chk("replay", o_issueReplay[p], er[p]);
         chk("success", o_issueSuccess[p], ok);
         chk("fu_vld", o_fu_vld[p], ok);
         chk("fb_idx", o_feedbackIdx[p], live ? pst[p].iqIdx : iqIdx_t'(0));
         chk("fu_busy", o_fu_busy[p], ebusy[p]);
         if (ok) begin
            ei.st = pst[p];
            for (int s = 0; s < NUMSRCS_INT; s++)
               ei.srcData[s] = opnd(pst[p].iprs[s], i_rf_rdata[p][s]);
            chk("fu_info", o_fu_info[p], ei);
         end
         for (int s = 0; s < NUMSRCS_INT; s++) begin
            chk("rf_ren", o_rf_ren[p][s], i_can_issue[p]);
            chk("rf_ridx", o_rf_ridx[p][s], i_issueState[p].iprs[s]);
         end
      end
      chk("replay_cnt", o_replay_cnt, ecnt);
   endtask

   task automatic tick();
      for (int p = 0; p < P; p++) begin
         pv[p]    = i_can_issue[p] && !i_flush;
         pst[p]   = i_issueState[p];
         pc1[p]   = hit(i_issueState[p]);
         ebusy[p] = !i_fu_rdy[p];
      end
      ecnt = ecnt + $countones(er);
      if (ecnt > CMAX) ecnt = CMAX;
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      check_model();
      tick();
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_fu_vld"}, o_fu_vld, 0);
      chk({tag, "_succ"}, o_issueSuccess, 0);
      chk({tag, "_repl"}, o_issueReplay, 0);
      chk({tag, "_fb"}, o_feedbackIdx, 0);
      chk({tag, "_info"}, o_fu_info, 0);
      chk({tag, "_busy"}, o_fu_busy, 0);
      chk({tag, "_cnt"}, o_replay_cnt, 0);
   endtask

   initial begin
      for (int p = 0; p < P; p++) pst[p] = '0;
      idle();
      #3;
      chk_zero("rst");
      @(posedge clk); #1;
      rst = 1'b1;

      // 1: plain issue, regfile operands
      idle(); set_op(0, 3, 5, 6); i_can_issue = 2'b01; step();
      idle(); i_rf_rdata[0][0] = 32'h11; i_rf_rdata[0][1] = 32'h22; check_model();
      chk("t1_vld", o_fu_vld, 2'b01);
      chk("t1_src0", o_fu_info[0].srcData[0], 32'h11);
      chk("t1_src1", o_fu_info[0].srcData[1], 32'h22);
      chk("t1_succ", o_issueSuccess, 2'b01);
      chk("t1_idx", o_feedbackIdx[0], 3);
      tick();

      // 2: two bypass hits on the same register, port 0 wins
      idle(); set_op(0, 4, 5, 6); i_can_issue = 2'b01; step();
      idle(); i_rf_rdata[0][0] = 32'h11; i_rf_rdata[0][1] = 32'h22;
      i_byp_vld = 2'b11; i_byp_iprd[0] = 6; i_byp_data[0] = 32'hBB;
      i_byp_iprd[1] = 6; i_byp_data[1] = 32'hAA; check_model();
      chk("t2_src0", o_fu_info[0].srcData[0], 32'h11);
      chk("t2_src1", o_fu_info[0].srcData[1], 32'hBB);
      tick();

      // 3: load cancel seen in i1 only
      idle(); set_op(0, 5, 5, 6); i_can_issue = 2'b01;
      i_ldc_vld = 2'b01; i_ldc_iprd[0] = 5; step();
      idle(); check_model();
      chk("t3_repl", o_issueReplay, 2'b01);
      chk("t3_vld", o_fu_vld, 2'b00);
      chk("t3_cnt0", o_replay_cnt, 0);
      tick();
      check_model();
      chk("t3_cnt1", o_replay_cnt, 1);
      tick();

      // 4: lane 1 FU not ready
      idle(); set_op(0, 6, 1, 2); set_op(1, 7, 3, 4); i_can_issue = 2'b11; step();
      idle(); i_fu_rdy = 2'b01; check_model();
      chk("t4_succ", o_issueSuccess, 2'b01);
      chk("t4_repl", o_issueReplay, 2'b10);
      tick();
      idle(); check_model();
      chk("t4_busy", o_fu_busy, 2'b10);
      tick();

      // 5: flush with both stages occupied
      idle(); set_op(0, 8, 1, 2); set_op(1, 9, 3, 4); i_can_issue = 2'b11; step();
      idle(); set_op(0, 10, 1, 2); set_op(1, 11, 3, 4); i_can_issue = 2'b11; i_flush = 1'b1;
      check_model();
      chk("t5_vld", o_fu_vld, 2'b00);
      chk("t5_fb", o_feedbackIdx, 0);
      chk("t5_repl", o_issueReplay, 2'b00);
      tick();
      idle(); check_model();
      chk("t5_empty", o_issueSuccess | o_issueReplay, 0);
      tick();

      for (int n = 0; n < 400; n++) begin
         rand_in();
         step();
      end

      // 6: drive the counter to saturation, then reset with i2 occupied
      for (int n = 0; n < 20; n++) begin
         idle(); set_op(0, 1, 1, 2); set_op(1, 2, 3, 4); i_can_issue = 2'b11; i_fu_rdy = 2'b00;
         step();
      end
      idle(); i_can_issue = 2'b11; i_fu_rdy = 2'b00; check_model();
      chk("t6_sat", o_replay_cnt, CMAX);
      chk("t6_pre_repl", o_issueReplay, 2'b11);
      rst = 1'b0;
      #2;
      chk_zero("t6");
      pv = '0; pc1 = '0; ebusy = '0; ecnt = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int n = 0; n < 50; n++) begin
         rand_in();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
